// File: rtl/mealy_stim_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first on x,
// repeating it rpt+1 times back to back, then pulses done.
module mealy_stim_gen #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned RPT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic [RPT_W-1:0] rpt,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [LEN_W-1:0] bit_cnt
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [RPT_W-1:0] pass_q, pass_d;
    logic [LEN_W-1:0] bit_cnt_d;
    logic             x_d, x_valid_d, done_d;
    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] shamt;
    logic [WIDTH-1:0] aligned;

    // Left-align the pattern so bit (L-1) always sits at the MSB of the shifter.
    assign len_eff = (len > WIDTH_L) ? WIDTH_L : len;
    assign shamt   = WIDTH_L - len_eff;
    assign aligned = data << shamt;

    assign ready = (state_q == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            shreg_q <= '0;
            len_q   <= '0;
            pass_q  <= '0;
            bit_cnt <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shreg_q <= shreg_d;
            len_q   <= len_d;
            pass_q  <= pass_d;
            bit_cnt <= bit_cnt_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        len_d     = len_q;
        pass_d    = pass_q;
        bit_cnt_d = '0;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (load && (len != '0)) begin
                    state_d   = SEND;
                    pat_d     = aligned;
                    shreg_d   = aligned << 1;
                    len_d     = len_eff;
                    pass_d    = rpt;
                    bit_cnt_d = len_eff - LEN_W'(1);
                    x_d       = aligned[WIDTH-1];
                    x_valid_d = 1'b1;
                end
            end
            SEND: begin
                x_valid_d = 1'b1;
                if (bit_cnt != '0) begin
                    bit_cnt_d = bit_cnt - LEN_W'(1);
                    x_d       = shreg_q[WIDTH-1];
                    shreg_d   = shreg_q << 1;
                end else if (pass_q != '0) begin
                    // Next pass restarts from the captured pattern with no gap.
                    pass_d    = pass_q - RPT_W'(1);
                    bit_cnt_d = len_q - LEN_W'(1);
                    x_d       = pat_q[WIDTH-1];
                    shreg_d   = pat_q << 1;
                end else begin
                    state_d   = IDLE;
                    x_valid_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mealy_stim_gen.sv
// Scoreboard bench for mealy_stim_gen: stimulus pushes cycle-stamped expected
// bits, a negedge monitor pops and compares whatever the DUT presents.
module tb_mealy_stim_gen;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] data;
    logic [4:0]  len;
    logic [3:0]  rpt;
    logic        ready;
    logic        x;
    logic        x_valid;
    logic        done;
    logic [4:0]  bit_cnt;

    typedef struct {
        int cyc;
        bit v;
        bit xb;
        int cnt;
        bit d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc       = 0;
    int   free_edge = 0;
    int   tests     = 0;
    int   fails     = 0;

    mealy_stim_gen #(.WIDTH(16), .LEN_W(5), .RPT_W(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .data    (data),
        .len     (len),
        .rpt     (rpt),
        .ready   (ready),
        .x       (x),
        .x_valid (x_valid),
        .done    (done),
        .bit_cnt (bit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: every cycle with x_valid or done must match the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            if (x_valid || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {30'd0, x_valid, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("x_valid", x_valid, e.v);
                    chk("x", x, e.xb);
                    chk("bit_cnt", bit_cnt, e.cnt);
                    chk("done", done, e.d);
                end
            end else begin
                chk("idle_x", x, 0);
                chk("idle_bit_cnt", bit_cnt, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk("missing_output", {30'd0, x_valid, done}, exp_q[0].v ? 32'd2 : 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; the reference model decides acceptance and timing.
    task automatic step(input bit ld, input logic [15:0] d, input logic [4:0] l,
                        input logic [3:0] r);
        int n;
        int lw;
        int t;
        @(posedge clock);
        #1;
        chk("ready", ready, (cyc + 1 >= free_edge));
        load = ld;
        data = d;
        len  = l;
        rpt  = r;
        if (ld && l != 0 && cyc + 1 >= free_edge) begin
            n  = cyc + 1;
            lw = (l > 16) ? 16 : int'(l);
            t  = (int'(r) + 1) * lw;
            for (int p = 0; p <= int'(r); p++)
                for (int i = lw - 1; i >= 0; i--)
                    exp_q.push_back('{n + p * lw + (lw - 1 - i), 1'b1, d[i], i, 1'b0});
            exp_q.push_back('{n + t, 1'b0, 1'b0, 0, 1'b1});
            free_edge = n + t + 1;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 16'h0, 5'd0, 4'd0);
    endtask

    // Leaves the bench so the next step() drives load into the done cycle.
    task automatic wait_free();
        int g = 0;
        while (cyc + 2 < free_edge && g < 2000) begin
            step(1'b0, 16'h0, 5'd0, 4'd0);
            g++;
        end
        if (g >= 2000) chk("wait_free_timeout", g, 0);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        data  = '0;
        len   = '0;
        rpt   = '0;
        #10;
        reset = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_x", x, 0);
        chk("rst_x_valid", x_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        idle(3);

        // Single pass 1101.
        step(1'b1, 16'h000D, 5'd4, 4'd0);
        wait_free();
        idle(2);

        // 110 three times, then 0xFFFF loaded in the done cycle.
        step(1'b1, 16'h0006, 5'd3, 4'd2);
        wait_free();
        step(1'b1, 16'hFFFF, 5'd16, 4'd0);
        idle(2);
        step(1'b1, 16'h0000, 5'd1, 4'd0);
        wait_free();
        idle(2);

        // len=0 is a no-op; len beyond WIDTH clamps to 16.
        step(1'b1, 16'hBEEF, 5'd0, 4'd3);
        idle(3);
        step(1'b1, 16'h8421, 5'd20, 4'd0);
        wait_free();
        idle(2);

        // Async reset on the third bit of an 8-bit transfer.
        step(1'b1, 16'h00A5, 5'd8, 4'd1);
        idle(2);
        @(posedge clock);
        #1;
        chk("pre_reset_x_valid", x_valid, 1);
        chk("pre_reset_bit_cnt", bit_cnt, 5);
        chk("pre_reset_x", x, 1);
        reset = 1'b1;
        load  = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_x", x, 0);
        chk("async_rst_x_valid", x_valid, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_bit_cnt", bit_cnt, 0);
        chk("async_rst_ready", ready, 1);
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b0;
        free_edge = cyc + 1;
        idle(2);
        step(1'b1, 16'h1234, 5'd5, 4'd0);
        wait_free();
        idle(2);

        // Randomized traffic, including loads while busy and in done cycles.
        repeat (400) begin
            step($urandom_range(0, 2) == 0, 16'($urandom), 5'($urandom_range(0, 20)),
                 4'($urandom_range(0, 3)));
        end
        wait_free();
        idle(3);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
